// File: rtl/data_memory_arbiter_pkg.sv
// Shared types for the data memory arbiter: FSM state and access owner encodings.
package data_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  // Width of the host wait counter; never narrower than one bit.
  function automatic int wait_cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bundles the CPU, host and memory-macro sides of the data memory arbiter.
interface data_memory_arbiter_if #(
  parameter int DATA_WIDTH = 11,
  parameter int ADDR_WIDTH = 11
);
  logic                  cpu_req_in;
  logic                  cpu_wr_in;
  logic [ADDR_WIDTH-1:0] cpu_addr_in;
  logic [DATA_WIDTH-1:0] cpu_wdata_in;
  logic                  cpu_gnt_out;
  logic                  cpu_done_out;
  logic [DATA_WIDTH-1:0] cpu_rdata_out;

  logic                  host_req_in;
  logic                  host_wr_in;
  logic [ADDR_WIDTH-1:0] host_addr_in;
  logic [DATA_WIDTH-1:0] host_wdata_in;
  logic                  host_gnt_out;
  logic                  host_done_out;
  logic [DATA_WIDTH-1:0] host_rdata_out;

  logic                  mem_en_out;
  logic                  mem_wr_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic [DATA_WIDTH-1:0] mem_wdata_out;
  logic [DATA_WIDTH-1:0] mem_rdata_in;

  logic                  owner_out;

  modport slave (
    input  cpu_req_in, cpu_wr_in, cpu_addr_in, cpu_wdata_in,
    output cpu_gnt_out, cpu_done_out, cpu_rdata_out,
    input  host_req_in, host_wr_in, host_addr_in, host_wdata_in,
    output host_gnt_out, host_done_out, host_rdata_out,
    output mem_en_out, mem_wr_out, mem_addr_out, mem_wdata_out,
    input  mem_rdata_in,
    output owner_out
  );

  modport master (
    output cpu_req_in, cpu_wr_in, cpu_addr_in, cpu_wdata_in,
    input  cpu_gnt_out, cpu_done_out, cpu_rdata_out,
    output host_req_in, host_wr_in, host_addr_in, host_wdata_in,
    input  host_gnt_out, host_done_out, host_rdata_out,
    input  mem_en_out, mem_wr_out, mem_addr_out, mem_wdata_out,
    output mem_rdata_in,
    input  owner_out
  );

endinterface

// File: rtl/data_memory_arbiter_select.sv
// Combinational priority pick: CPU first, host when alone or when it has waited long enough.
module data_memory_arbiter_select
  import data_memory_arbiter_pkg::*;
(
  input  logic   cpu_req_in,
  input  logic   host_req_in,
  input  logic   host_starved_in,
  output logic   valid_out,
  output owner_e owner_out
);

  always_comb begin
    valid_out = cpu_req_in | host_req_in;
    owner_out = OWN_CPU;
    if (host_req_in && (!cpu_req_in || host_starved_in)) begin
      owner_out = OWN_HOST;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares a single-port synchronous data memory between the CPU and a host port,
// one access per ISSUE/RESP pair, with a starvation guard for the host.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 11,
  parameter int ADDR_WIDTH    = 11,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  data_memory_arbiter_if.slave bus
);

  localparam int              WAIT_W   = wait_cnt_width(HOST_MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_RESP  = RESP;

  logic [1:0]            state_q, state_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  owner_e                owner_q, owner_d;
  logic                  req_wr_q, req_wr_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic                  cpu_done_q, cpu_done_d;
  logic                  host_done_q, host_done_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;

  logic   decide;
  logic   host_starved;
  logic   sel_valid;
  owner_e sel_owner;
  logic   issue;

  assign decide       = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign host_starved = (wait_cnt_q == WAIT_MAX);
  assign issue        = (state_q == ST_ISSUE);

  data_memory_arbiter_select u_select (
    .cpu_req_in      (bus.cpu_req_in),
    .host_req_in     (bus.host_req_in),
    .host_starved_in (host_starved),
    .valid_out       (sel_valid),
    .owner_out       (sel_owner)
  );

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    owner_d      = owner_q;
    req_wr_d     = req_wr_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    cpu_done_d   = 1'b0;
    host_done_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;

    case (state_q)
      ST_IDLE, ST_RESP: state_d = sel_valid ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:         state_d = ST_RESP;
      default:          state_d = ST_IDLE;
    endcase

    if (decide && sel_valid) begin
      owner_d = sel_owner;
      if (sel_owner == OWN_HOST) begin
        req_wr_d    = bus.host_wr_in;
        req_addr_d  = bus.host_addr_in;
        req_wdata_d = bus.host_wdata_in;
      end else begin
        req_wr_d    = bus.cpu_wr_in;
        req_addr_d  = bus.cpu_addr_in;
        req_wdata_d = bus.cpu_wdata_in;
      end
    end

    // Only decisions the host actually lost while asking count toward starvation.
    if (decide) begin
      if (!bus.host_req_in || (sel_owner == OWN_HOST)) begin
        wait_cnt_d = '0;
      end else if (!host_starved) begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    end

    if (state_q == ST_RESP) begin
      cpu_done_d  = (owner_q == OWN_CPU);
      host_done_d = (owner_q == OWN_HOST);
      if (!req_wr_q) begin
        if (owner_q == OWN_CPU) begin
          cpu_rdata_d = bus.mem_rdata_in;
        end else begin
          host_rdata_d = bus.mem_rdata_in;
        end
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      owner_q      <= OWN_CPU;
      req_wr_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      cpu_done_q   <= 1'b0;
      host_done_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      owner_q      <= owner_d;
      req_wr_q     <= req_wr_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      cpu_done_q   <= cpu_done_d;
      host_done_q  <= host_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Memory-side signals are gated so the macro sees nothing outside ISSUE.
  assign bus.mem_en_out     = issue;
  assign bus.mem_wr_out     = issue & req_wr_q;
  assign bus.mem_addr_out   = issue ? req_addr_q : '0;
  assign bus.mem_wdata_out  = issue ? req_wdata_q : '0;
  assign bus.cpu_gnt_out    = issue && (owner_q == OWN_CPU);
  assign bus.host_gnt_out   = issue && (owner_q == OWN_HOST);
  assign bus.cpu_done_out   = cpu_done_q;
  assign bus.host_done_out  = host_done_q;
  assign bus.cpu_rdata_out  = cpu_rdata_q;
  assign bus.host_rdata_out = host_rdata_q;
  assign bus.owner_out      = owner_q;

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port synchronous data memory between the CPU datapath (STO/LD in EXEC) and a host port (program loader / debug monitor).
- Sits between the CPU memory interface, the host interface and the data memory macro.
- Fixed CPU priority, plus a starvation guard that guarantees host progress.
- Memory has 1-cycle synchronous read latency.

Parameters:
- DATA_WIDTH, 11, data word width.
- ADDR_WIDTH, 11, data memory address width.
- HOST_MAX_WAIT, 4, number of consecutive lost decisions after which the host wins; minimum 1.

Ports:
- clock_in  input  1  system clock
- reset_in  input  1  reset
- cpu_req_in  input  1  CPU access request, level
- cpu_wr_in  input  1  CPU 1=write, 0=read
- cpu_addr_in  input  ADDR_WIDTH  CPU address
- cpu_wdata_in  input  DATA_WIDTH  CPU write data
- cpu_gnt_out  output  1  CPU access issued this cycle
- cpu_done_out  output  1  CPU access complete, 1-cycle pulse
- cpu_rdata_out  output  DATA_WIDTH  CPU read data
- host_req_in, host_wr_in, host_addr_in, host_wdata_in  input  1/1/ADDR_WIDTH/DATA_WIDTH  host equivalents
- host_gnt_out, host_done_out  output  1  host equivalents
- host_rdata_out  output  DATA_WIDTH  host read data
- mem_en_out  output  1  memory enable
- mem_wr_out  output  1  memory write enable
- mem_addr_out  output  ADDR_WIDTH  memory address
- mem_wdata_out  output  DATA_WIDTH  memory write data
- mem_rdata_in  input  DATA_WIDTH  memory read data, valid the cycle after an enabled read
- owner_out  output  1  0=CPU, 1=host; owner of the last issued access

Behaviour:
- Reset: reset_in is asynchronous, active-low; clock is clock_in. All outputs are 0, state is IDLE, wait counter is 0. Asserting reset mid-access abandons the access and no done pulse is produced.
- States:
  - IDLE: arbitrate. If any request is present → ISSUE, else stay.
  - ISSUE: mem_en_out=1; mem_wr/addr/wdata come from registered copies of the winner's request; winner's gnt_out=1. Always → RESP.
  - RESP: memory output is valid; capture mem_rdata_in if the access was a read. Arbitrate again: if any request → ISSUE (back-to-back), else → IDLE.
- Decision cycle (IDLE or RESP):
  - Winner's wr/addr/wdata are registered at the clock edge.
  - The request must be held stable until the requester sees gnt.
  - A req high in the cycle after gnt counts as a new request.
- Completion:
  - done_out for the owner pulses in the cycle after RESP.
  - rdata_out updates in that same cycle for reads only; it holds otherwise.
  - Writes pulse done with rdata_out unchanged.
- Latency: req sampled at edge N → gnt/mem_en in cycle N+1 → done in cycle N+3. Peak throughput is one access per 2 cycles.
- Priority:
  - Only CPU requesting → CPU. Only host requesting → host.
  - Both requesting with wait_cnt < HOST_MAX_WAIT → CPU.
  - Both requesting with wait_cnt == HOST_MAX_WAIT → host.
- wait_cnt (width $clog2(HOST_MAX_WAIT+1)):
  - +1 at each decision where the host requests and the CPU wins.
  - Clears when the host is granted or host_req_in is low at a decision.
  - Saturates at HOST_MAX_WAIT.
- Only one gnt is high in any cycle. gnt and mem_en are never asserted outside ISSUE.
- owner_out updates at entry to ISSUE and holds until the next ISSUE.
- mem_wr_out is 0 whenever mem_en_out is 0.

Decomposition:
- Package data_memory_arbiter_pkg:
  - state enum IDLE/ISSUE/RESP (2 bits).
  - owner enum OWN_CPU=0/OWN_HOST=1.
- Sub-module data_memory_arbiter_select: combinational priority pick from cpu_req, host_req and the wait-counter-at-max flag; outputs a valid flag and the owner.
- The FSM, wait counter and request/response registers stay in the top module.

Test Plan:
- Reset: hold reset_in=0 mid-ISSUE → all outputs 0; after release no done pulse and state IDLE.
- CPU write then read: write addr 0x005, data 0x2AB; then read 0x005 → mem_en/mem_wr in cycle N+1, cpu_done at N+3, cpu_rdata_out=0x2AB.
- Host only: read addr 0x7FF holding 0x123 → host_gnt one cycle, host_done at N+3, host_rdata_out=0x123, owner_out=1, cpu_* quiet.
- Simultaneous first request: cpu and host req together from IDLE → CPU granted first, host granted at the next decision (RESP), back-to-back ISSUE with no IDLE gap.
- Starvation guard: CPU requests continuously, host requests continuously, HOST_MAX_WAIT=4 → CPU wins 4 decisions, host wins the 5th, then CPU resumes.
- Write data integrity: host writes 0x3FF to 0x010 while the CPU's pending request holds different wdata → memory sees 0x3FF at 0x010 only in the host ISSUE cycle; read-back by the CPU returns 0x3FF.
